// File: rtl/fft_pkg.sv
// Shared constants and twiddle table for the 64-point radix-2 DIF datapath.
// tw_lookup(k) returns W64^k = (round(4096*cos), -round(4096*sin)) in Q4.12.
package fft_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TW_W   = 16;
  localparam int unsigned PROD_W = DATA_W + TW_W;
  localparam int unsigned N_PTS  = 64;
  localparam int unsigned LOG2N  = 6;

  typedef struct packed {
    logic signed [TW_W-1:0] wr;
    logic signed [TW_W-1:0] wi;
  } tw_t;

  localparam logic signed [TW_W-1:0] TW_RE [32] = '{
     16'sd4096,  16'sd4076,  16'sd4017,  16'sd3920,  16'sd3784,  16'sd3612,  16'sd3406,  16'sd3166,
     16'sd2896,  16'sd2598,  16'sd2276,  16'sd1931,  16'sd1567,  16'sd1189,  16'sd799,   16'sd401,
     16'sd0,    -16'sd401,  -16'sd799,  -16'sd1189, -16'sd1567, -16'sd1931, -16'sd2276, -16'sd2598,
    -16'sd2896, -16'sd3166, -16'sd3406, -16'sd3612, -16'sd3784, -16'sd3920, -16'sd4017, -16'sd4076
  };

  localparam logic signed [TW_W-1:0] TW_IM [32] = '{
     16'sd0,    -16'sd401,  -16'sd799,  -16'sd1189, -16'sd1567, -16'sd1931, -16'sd2276, -16'sd2598,
    -16'sd2896, -16'sd3166, -16'sd3406, -16'sd3612, -16'sd3784, -16'sd3920, -16'sd4017, -16'sd4076,
    -16'sd4096, -16'sd4076, -16'sd4017, -16'sd3920, -16'sd3784, -16'sd3612, -16'sd3406, -16'sd3166,
    -16'sd2896, -16'sd2598, -16'sd2276, -16'sd1931, -16'sd1567, -16'sd1189, -16'sd799,  -16'sd401
  };

  function automatic tw_t tw_lookup(input logic [4:0] k);
    tw_t t;
    t.wr = TW_RE[k];
    t.wi = TW_IM[k];
    return t;
  endfunction

endpackage

// File: rtl/twiddle_rom_64.sv
// Combinational twiddle lookup, k[4:0] -> (wr, wi) in Q4.12.
// Ports: k (index), wr/wi (signed twiddle components).
module twiddle_rom_64
  import fft_pkg::*;
(
  input  logic [4:0]             k,
  output logic signed [TW_W-1:0] wr,
  output logic signed [TW_W-1:0] wi
);

  tw_t tw_c;

  always_comb begin
    tw_c = tw_lookup(k);
    wr   = tw_c.wr;
    wi   = tw_c.wi;
  end

endmodule

// File: rtl/twiddle_cmul_pipe.sv
// Pipelined complex twiddle multiplier for one DIF stage.
// Ports: clk, rst_n (async active-low); in_valid/frame_start/stage and
// Data_in_re/im (Q4.12) in; out_valid/out_last and Data_out_re/im (Q8.24) out.
// Three register stages: P1 sample+twiddle, P2 partial products, P3 sum/diff.
module twiddle_cmul_pipe
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic [2:0]        stage,
  input  logic [DATA_W-1:0] Data_in_re,
  input  logic [DATA_W-1:0] Data_in_im,
  output logic              out_valid,
  output logic              out_last,
  output logic [PROD_W-1:0] Data_out_re,
  output logic [PROD_W-1:0] Data_out_im
);

  logic [LOG2N-1:0] n_q, n_d, n_eff_c, h_c;
  logic             lower_c;
  logic [4:0]       k_c;
  logic signed [TW_W-1:0] rom_wr, rom_wi;

  logic signed [DATA_W-1:0] ar_q, ar_d, ai_q, ai_d;
  logic signed [TW_W-1:0]   wr_q, wr_d, wi_q, wi_d;
  logic                     v1_q, v1_d, last1_q, last1_d;

  logic signed [PROD_W-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d;
  logic signed [PROD_W-1:0] p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic                     v2_q, v2_d, last2_q, last2_d;

  logic [PROD_W-1:0] re_q, re_d, im_q, im_d;
  logic              ov_q, ov_d, ol_q, ol_d;

  twiddle_rom_64 u_rom (
    .k  (k_c),
    .wr (rom_wr),
    .wi (rom_wi)
  );

  // Index, twiddle select and pipeline next-state.
  always_comb begin
    n_d     = n_q;
    ar_d    = ar_q;
    ai_d    = ai_q;
    wr_d    = wr_q;
    wi_d    = wi_q;
    p_rr_d  = p_rr_q;
    p_ii_d  = p_ii_q;
    p_ri_d  = p_ri_q;
    p_ir_d  = p_ir_q;
    re_d    = re_q;
    im_d    = im_q;

    n_eff_c = frame_start ? '0 : n_q;
    // h = 32>>stage; lower leg when bit log2(h) of n_eff is set. h is 0 for stage 6/7.
    h_c     = LOG2N'(6'd32 >> stage);
    lower_c = (stage < 3'd6) && ((n_eff_c & h_c) != '0);
    k_c     = lower_c ? 5'((n_eff_c & (h_c - 6'd1)) << stage) : 5'd0;

    v1_d    = in_valid;
    last1_d = in_valid && (n_eff_c == LOG2N'(N_PTS - 1));
    if (in_valid) begin
      n_d  = n_eff_c + 6'd1;
      ar_d = Data_in_re;
      ai_d = Data_in_im;
      wr_d = rom_wr;
      wi_d = rom_wi;
    end

    v2_d    = v1_q;
    last2_d = v1_q && last1_q;
    if (v1_q) begin
      p_rr_d = PROD_W'(ar_q) * PROD_W'(wr_q);
      p_ii_d = PROD_W'(ai_q) * PROD_W'(wi_q);
      p_ri_d = PROD_W'(ar_q) * PROD_W'(wi_q);
      p_ir_d = PROD_W'(ai_q) * PROD_W'(wr_q);
    end

    ov_d = v2_q;
    ol_d = v2_q && last2_q;
    if (v2_q) begin
      re_d = p_rr_q - p_ii_q;
      im_d = p_ri_q + p_ir_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      ar_q    <= '0;
      ai_q    <= '0;
      wr_q    <= '0;
      wi_q    <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      p_rr_q  <= '0;
      p_ii_q  <= '0;
      p_ri_q  <= '0;
      p_ir_q  <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      n_q     <= n_d;
      ar_q    <= ar_d;
      ai_q    <= ai_d;
      wr_q    <= wr_d;
      wi_q    <= wi_d;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      p_rr_q  <= p_rr_d;
      p_ii_q  <= p_ii_d;
      p_ri_q  <= p_ri_d;
      p_ir_q  <= p_ir_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
      re_q    <= re_d;
      im_q    <= im_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_last    = ol_q;
  assign Data_out_re = re_q;
  assign Data_out_im = im_q;

endmodule

// File: tb/tb_twiddle_cmul_pipe.sv
// Randomized + directed bench for twiddle_cmul_pipe against a trig-based model.
module tb_twiddle_cmul_pipe;

  logic        clk, rst_n, in_valid, frame_start;
  logic [2:0]  stage;
  logic [15:0] Data_in_re, Data_in_im;
  logic        out_valid, out_last;
  logic [31:0] Data_out_re, Data_out_im;

  twiddle_cmul_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .stage       (stage),
    .Data_in_re  (Data_in_re),
    .Data_in_im  (Data_in_im),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .Data_out_re (Data_out_re),
    .Data_out_im (Data_out_im)
  );

  typedef struct {
    int          due;
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          model_n = 0;
  logic [31:0] last_re = '0;
  logic [31:0] last_im = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare outputs visible this cycle with the scoreboard.
  task automatic check_out();
    exp_t e;
    logic exp_v;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    if (exp_v) begin
      e = q.pop_front();
      chk("re",   {32'd0, Data_out_re}, {32'd0, e.re});
      chk("im",   {32'd0, Data_out_im}, {32'd0, e.im});
      chk("last", {63'd0, out_last},    {63'd0, e.last});
      last_re = e.re;
      last_im = e.im;
    end else begin
      chk("hold_re", {32'd0, Data_out_re}, {32'd0, last_re});
      chk("hold_im", {32'd0, Data_out_im}, {32'd0, last_im});
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
  endtask

  function automatic int rnd_q12(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  // One cycle: check outputs, drive new inputs, update the model.
  task automatic step(input logic v, input logic fs, input int st, input int are, input int aim,
                      input logic dir, input int dre, input int dim);
    int ne, h, k, wr, wi;
    real ang;
    shortint ar, ai;
    longint re, im;
    exp_t e;
    @(negedge clk);
    check_out();
    in_valid    = v;
    frame_start = fs;
    stage       = 3'(st);
    Data_in_re  = 16'(are);
    Data_in_im  = 16'(aim);
    if (v) begin
      ne = fs ? 0 : model_n;
      model_n = (ne + 1) % 64;
      if (st > 5) k = 0;
      else begin
        h = 32 >> st;
        k = ((ne % (2 * h)) < h) ? 0 : ((ne % h) << st);
      end
      ang = 2.0 * 3.14159265358979 * k / 64.0;
      wr  = rnd_q12(4096.0 * $cos(ang));
      wi  = -rnd_q12(4096.0 * $sin(ang));
      ar  = shortint'(16'(are));
      ai  = shortint'(16'(aim));
      re  = longint'(ar) * wr - longint'(ai) * wi;
      im  = longint'(ar) * wi + longint'(ai) * wr;
      e.due  = cyc + 3;
      e.re   = dir ? 32'(dre) : 32'(re);
      e.im   = dir ? 32'(dim) : 32'(im);
      e.last = (ne == 63);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 0, int'($urandom), int'($urandom), 1'b0, 0, 0);
  endtask

  task automatic rnd(input logic fs, input int st);
    step(1'b1, fs, st, int'($urandom), int'($urandom), 1'b0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; stage = '0;
    Data_in_re = '0; Data_in_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_last",  {63'd0, out_last},  64'd0);
    chk("rst_re",    {32'd0, Data_out_re}, 64'd0);
    chk("rst_im",    {32'd0, Data_out_im}, 64'd0);
    rst_n = 1'b1;

    // Stage 0 frame with directed unity, k=8 and k=16 points.
    step(1'b1, 1'b1, 0, 100, -50, 1'b1, 409600, -204800);
    for (int i = 1; i < 64; i++) begin
      if (i == 40)      step(1'b1, 1'b0, 0, 4096, 0, 1'b1, 11862016, -11862016);
      else if (i == 48) step(1'b1, 1'b0, 0, 100, -50, 1'b1, -204800, -409600);
      else              rnd(1'b0, 0);
    end
    // Counter wraps to n=0 without frame_start.
    rnd(1'b0, 0);
    rnd(1'b0, 0);

    // Stage 2, n=9 -> k=4.
    for (int i = 0; i < 16; i++) begin
      if (i == 9) step(1'b1, 1'b0, 2, 4096, 0, 1'b1, 4096 * 3784, -4096 * 1567);
      else        rnd(i == 0, 2);
    end

    // Random traffic with bubbles, random stages and occasional restarts.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else rnd(($urandom_range(0, 40) == 0), int'($urandom_range(0, 7)));
    end
    idle(5);

    // Reset with two samples in flight.
    rnd(1'b1, 0);
    rnd(1'b0, 0);
    @(negedge clk);
    check_out();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_last",  {63'd0, out_last},  64'd0);
    chk("arst_re",    {32'd0, Data_out_re}, 64'd0);
    chk("arst_im",    {32'd0, Data_out_im}, 64'd0);
    q.delete();
    model_n = 0;
    last_re = '0;
    last_im = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Post-reset frame without frame_start; corner operand at k=8.
    for (int i = 0; i < 64; i++) begin
      if (i == 40) step(1'b1, 1'b0, 0, -32768, -32768, 1'b1, -189792256, 0);
      else         rnd(1'b0, 0);
    end
    idle(6);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/twiddle_cmul_pipe.md
Name: twiddle_cmul_pipe

Overview:
- Pipelined complex twiddle multiplier for the 64-point radix-2 DIF datapath. Sits between butterfly stage s and the two 32b-to-16b bit-adjust instances, one for the real word and one for the imaginary word.
- Takes 16-bit Q4.12 complex samples in natural intra-frame order. Selects the twiddle W64^k from an internal ROM using its own sample counter and the stage number.
- Emits full-precision 32-bit Q8.24 complex products; the bit adjusters downstream cut these back to Q4.12.

Parameters:
- DATA_W, 16, sample component width, signed Q4.12.
- TW_W, 16, twiddle component width, signed Q4.12 (1.0 = 4096).
- PROD_W, 32, output component width, signed Q8.24; must equal DATA_W+TW_W.
- N_PTS, 64, frame length; only 64 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe.
- frame_start  in  1  qualified by in_valid; marks this sample as n=0.
- stage  in  3  DIF stage index 0..5, sampled with each valid sample.
- Data_in_re  in  16  signed real input.
- Data_in_im  in  16  signed imaginary input.
- out_valid  out  1  product strobe.
- out_last  out  1  asserted with out_valid for sample n=63.
- Data_out_re  out  32  signed real product.
- Data_out_im  out  32  signed imaginary product.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_last=0, Data_out_re=0, Data_out_im=0. Sample counter n=0; all pipeline valid bits 0.
  - Reset mid-frame discards in-flight samples; no partial outputs appear after release.
- No backpressure. One sample may be accepted every cycle; bubbles are allowed. Non-valid cycles do not advance n.
- Sample counter:
  - On in_valid: effective index n_eff = frame_start ? 0 : n; next n = (n_eff+1) mod 64.
  - Counter wraps 63->0 without needing frame_start.
  - frame_start mid-frame restarts numbering immediately.
- Twiddle selection, with h = 32>>stage:
  - If (n_eff mod 2h) < h, the sample is an upper-leg sample: k=0 (unity).
  - Otherwise k = (n_eff mod h) << stage.
  - stage 6 or 7 forces k=0.
- ROM: 32 entries, wr[k] = round(4096*cos(2*pi*k/64)) and wi[k] = -round(4096*sin(2*pi*k/64)). Examples:
  - k=0: (4096, 0).
  - k=8: (2896, -2896).
  - k=16: (0, -4096).
- Arithmetic:
  - re = ar*wr - ai*wi; im = ar*wi + ai*wr.
  - All operands signed. Products are 32-bit; the sum and difference are computed modulo 2^32 (wrap, no saturation).
- Pipeline, latency 3 cycles from the in_valid edge to the out_valid edge:
  - P1: register the sample and the ROM twiddle.
  - P2: register the four 32-bit partial products.
  - P3: register the add/sub results, out_valid and out_last.
- out_last = (n_eff==63), carried through the pipeline with its sample.
- When out_valid=0, Data_out_* hold their last value.
- frame_start and counter wrap in the same cycle: frame_start wins, so n_eff=0.

Decomposition:
- Shared package fft_pkg: DATA_W, TW_W, PROD_W, N_PTS, LOG2N=6, and a twiddle ROM constant function/table of 32 (wr, wi) pairs. This table is reused by the other stage multipliers.
- One natural sub-module: twiddle_rom_64 (combinational lookup, k[4:0] -> wr, wi). The P1 register lives in twiddle_cmul_pipe.

Test Plan:
1. stage=0, frame_start on sample 0, input (100,-50) at n=0 -> 3 cycles later out_valid=1, re=409600, im=-204800 (unity twiddle).
2. stage=0, n=48 (k=16), input (100,-50) -> re=-204800, im=-409600.
3. stage=0, n=40 (k=8), input (4096,0) -> re=11862016, im=-11862016. Then stage=2, n=9 (h=8, lower leg, k=(9 mod 8)<<2=4), input (4096,0) -> re=4096*round(4096*cos(pi/8))=4096*3784, im=-4096*1567.
4. Stream 64 consecutive valid samples, then 2 more with no frame_start -> out_last exactly on the 64th output. The 65th sample is treated as n=0.
5. Random in_valid bubbles over a frame -> every output matches the golden model. out_valid count equals input count; spacing is preserved.
6. Assert rst_n low for one cycle with 2 samples in flight -> outputs drop to 0 asynchronously and no stale out_valid appears. After release, the next sample without frame_start uses n=0. Also check corner input (-32768,-32768) at k=8 -> exact modulo-2^32 results.
